block_0_access_arbiter: RTL and testbench

BLOCK_0_ACCESS_ARBITER -- requirements
Module: block_0_access_arbiter

---
 rtl/block_0_access_arbiter_pkg.sv | 15 +
 rtl/block_0_rr_picker.sv | 30 +++
 rtl/block_0_access_arbiter.sv | 167 ++++++++++++++++
 tb/tb_block_0_access_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/block_0_access_arbiter_pkg.sv
// Shared types for the block_0 access arbiter: FSM states and bus status codes.
package block_0_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    localparam logic [1:0] OKAY         = 2'b00;
    localparam logic [1:0] EXOKAY       = 2'b01;
    localparam logic [1:0] SLAVE_ERROR  = 2'b10;
    localparam logic [1:0] DECODE_ERROR = 2'b11;

endpackage

// File: rtl/block_0_rr_picker.sv
// Combinational round-robin picker: searches upward from last_grant+1,
// returns a one-hot grant (all zero when nothing requests).
module block_0_rr_picker #(
    parameter int NUM_HOSTS = 2,
    parameter int IDX_W     = $clog2(NUM_HOSTS)
) (
    input  logic [NUM_HOSTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_HOSTS-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_HOSTS; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_HOSTS)
                idx = idx - NUM_HOSTS;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_0_access_arbiter.sv
// Round-robin arbiter from NUM_HOSTS hosts onto the block_0 register bus.
// Optional watchdog: define BLOCK_0_ACCESS_ARBITER_TIMEOUT_EN.
module block_0_access_arbiter #(
    parameter int NUM_HOSTS      = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [NUM_HOSTS-1:0]                i_host_valid,
    input  logic [NUM_HOSTS-1:0]                i_host_write,
    input  logic [NUM_HOSTS*ADDRESS_WIDTH-1:0]  i_host_address,
    input  logic [NUM_HOSTS*DATA_WIDTH-1:0]     i_host_write_data,
    input  logic [NUM_HOSTS*DATA_WIDTH/8-1:0]   i_host_strobe,
    output logic [NUM_HOSTS-1:0]                o_host_ready,
    output logic [1:0]                          o_host_status,
    output logic [DATA_WIDTH-1:0]               o_host_read_data,
    output logic                                o_reg_valid,
    output logic                                o_reg_write,
    output logic [ADDRESS_WIDTH-1:0]            o_reg_address,
    output logic [DATA_WIDTH-1:0]               o_reg_write_data,
    output logic [DATA_WIDTH/8-1:0]             o_reg_strobe,
    input  logic                                i_reg_ready,
    input  logic [1:0]                          i_reg_status,
    input  logic [DATA_WIDTH-1:0]               i_reg_read_data
);

    import block_0_access_arbiter_pkg::*;

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W        = $clog2(NUM_HOSTS);

    state_t                   state_q;
    state_t                   state_d;
    logic [IDX_W-1:0]         last_grant_q;
    logic [IDX_W-1:0]         grant_q;
    logic [NUM_HOSTS-1:0]     pick_oh;
    logic [IDX_W-1:0]         pick_idx;
    logic [ADDRESS_WIDTH-1:0] pick_addr;
    logic                     pick_any;
    logic                     misaligned;
    logic                     timeout;

    logic                     req_write_q;
    logic [ADDRESS_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0]    req_wdata_q;
    logic [STROBE_WIDTH-1:0]  req_strobe_q;
    logic [1:0]               resp_status_q;
    logic [DATA_WIDTH-1:0]    resp_data_q;

    block_0_rr_picker #(
        .NUM_HOSTS (NUM_HOSTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req        (i_host_valid),
        .last_grant (last_grant_q),
        .grant      (pick_oh)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_HOSTS; i++)
            if (pick_oh[i])
                pick_idx = IDX_W'(i);
    end

    assign pick_any   = |pick_oh;
    assign pick_addr  = i_host_address[pick_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign misaligned = (pick_addr[1:0] != 2'b00);

`ifdef BLOCK_0_ACCESS_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;

    // Held at zero outside ACCESS, so it is clear on every entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            tmo_cnt_q <= '0;
        else if (state_q != ST_ACCESS)
            tmo_cnt_q <= '0;
        else
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    assign timeout = (state_q == ST_ACCESS)
                  && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any)
                    state_d = misaligned ? ST_RESPOND : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (i_reg_ready || timeout)
                    state_d = ST_RESPOND;
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_grant_q  <= IDX_W'(NUM_HOSTS - 1);
            grant_q       <= '0;
            req_write_q   <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            req_strobe_q  <= '0;
            resp_status_q <= OKAY;
            resp_data_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q      <= pick_idx;
                        req_write_q  <= i_host_write[pick_idx];
                        req_addr_q   <= pick_addr;
                        req_wdata_q  <= i_host_write_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                        req_strobe_q <= i_host_strobe[pick_idx*STROBE_WIDTH +: STROBE_WIDTH];
                        if (misaligned) begin
                            resp_status_q <= DECODE_ERROR;
                            resp_data_q   <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (i_reg_ready) begin
                        resp_status_q <= i_reg_status;
                        resp_data_q   <= i_reg_read_data;
                    end else if (timeout) begin
                        resp_status_q <= SLAVE_ERROR;
                        resp_data_q   <= '0;
                    end
                end
                ST_RESPOND: last_grant_q <= grant_q;
                default: ;
            endcase
        end
    end

    assign o_reg_valid      = (state_q == ST_ACCESS);
    assign o_reg_write      = req_write_q;
    assign o_reg_address    = req_addr_q;
    assign o_reg_write_data = req_wdata_q;
    assign o_reg_strobe     = req_strobe_q;

    assign o_host_ready = (state_q == ST_RESPOND)
                        ? (NUM_HOSTS'(1) << grant_q) : '0;
    assign o_host_status = (state_q == ST_RESPOND) ? resp_status_q : OKAY;
    assign o_host_read_data = (state_q == ST_RESPOND && !req_write_q)
                            ? resp_data_q : '0;

endmodule

// File: tb/tb_block_0_access_arbiter.sv
// Directed self-checking bench for block_0_access_arbiter (2 hosts).
module tb_block_0_access_arbiter;

    localparam int NH = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NH-1:0]     host_valid;
    logic [NH-1:0]     host_write;
    logic [NH*AW-1:0]  host_address;
    logic [NH*DW-1:0]  host_write_data;
    logic [NH*SW-1:0]  host_strobe;
    logic [NH-1:0]     host_ready;
    logic [1:0]        host_status;
    logic [DW-1:0]     host_read_data;
    logic              reg_valid;
    logic              reg_write;
    logic [AW-1:0]     reg_address;
    logic [DW-1:0]     reg_write_data;
    logic [SW-1:0]     reg_strobe;
    logic              reg_ready;
    logic [1:0]        reg_status;
    logic [DW-1:0]     reg_read_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    block_0_access_arbiter #(
        .NUM_HOSTS      (NH),
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_host_valid      (host_valid),
        .i_host_write      (host_write),
        .i_host_address    (host_address),
        .i_host_write_data (host_write_data),
        .i_host_strobe     (host_strobe),
        .o_host_ready      (host_ready),
        .o_host_status     (host_status),
        .o_host_read_data  (host_read_data),
        .o_reg_valid       (reg_valid),
        .o_reg_write       (reg_write),
        .o_reg_address     (reg_address),
        .o_reg_write_data  (reg_write_data),
        .o_reg_strobe      (reg_strobe),
        .i_reg_ready       (reg_ready),
        .i_reg_status      (reg_status),
        .i_reg_read_data   (reg_read_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        host_valid      = '0;
        host_write      = '0;
        host_address    = '0;
        host_write_data = '0;
        host_strobe     = '0;
        reg_ready       = 1'b0;
        reg_status      = 2'b00;
        reg_read_data   = '0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_reg_valid", 64'(reg_valid), 64'd0);
        chk("rst_host_ready", 64'(host_ready), 64'd0);
        chk("rst_host_status", 64'(host_status), 64'd0);
        chk("rst_host_rdata", 64'(host_read_data), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // host0 read 0x04, ready on the third ACCESS cycle
        host_valid   = 2'b01;
        host_address = {8'h00, 8'h04};
        tick();
        chk("rd_valid_c1", 64'(reg_valid), 64'd1);
        chk("rd_addr", 64'(reg_address), 64'h04);
        chk("rd_write", 64'(reg_write), 64'd0);
        tick();
        chk("rd_valid_c2", 64'(reg_valid), 64'd1);
        tick();
        reg_ready     = 1'b1;
        reg_read_data = 32'h1;
        reg_status    = 2'b00;
        tick();
        chk("rd_ready_c4", 64'(host_ready), 64'h1);
        chk("rd_data_c4", 64'(host_read_data), 64'h1);
        chk("rd_status_c4", 64'(host_status), 64'd0);
        chk("rd_regvalid_c4", 64'(reg_valid), 64'd0);
        idle_inputs();
        tick();
        chk("idle_ready", 64'(host_ready), 64'd0);
        chk("idle_status", 64'(host_status), 64'd0);
        chk("idle_rdata", 64'(host_read_data), 64'd0);

        // host1 write 0x50
        host_valid      = 2'b10;
        host_write      = 2'b10;
        host_address    = {8'h50, 8'h00};
        host_write_data = {32'hA5A5A5A5, 32'h0};
        host_strobe     = {4'hF, 4'h0};
        tick();
        chk("wr_valid", 64'(reg_valid), 64'd1);
        chk("wr_write", 64'(reg_write), 64'd1);
        chk("wr_addr", 64'(reg_address), 64'h50);
        chk("wr_wdata", 64'(reg_write_data), 64'hA5A5A5A5);
        chk("wr_strobe", 64'(reg_strobe), 64'hF);
        reg_ready     = 1'b1;
        reg_status    = 2'b01;
        reg_read_data = 32'hDEAD;
        tick();
        chk("wr_ready", 64'(host_ready), 64'h2);
        chk("wr_rdata_zero", 64'(host_read_data), 64'd0);
        chk("wr_status", 64'(host_status), 64'd1);
        idle_inputs();
        tick();

        // both hosts hold valid: grants must alternate 0,1,0,1
        host_valid    = 2'b11;
        host_address  = {8'h20, 8'h10};
        reg_ready     = 1'b1;
        reg_read_data = 32'h55;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (host_ready == '0 && n < 20) begin
                tick();
                n++;
            end
            chk("rr_grant", 64'(host_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            if (k == 3)
                idle_inputs();
            tick();
        end

        // misaligned address: no downstream access, decode error
        host_valid   = 2'b01;
        host_address = {8'h00, 8'h06};
        tick();
        chk("dec_regvalid", 64'(reg_valid), 64'd0);
        chk("dec_ready", 64'(host_ready), 64'h1);
        chk("dec_status", 64'(host_status), 64'd3);
        chk("dec_rdata", 64'(host_read_data), 64'd0);
        idle_inputs();
        tick();

        // reset during ACCESS; host0 must win first afterwards
        host_valid   = 2'b11;
        host_address = {8'h0C, 8'h08};
        tick();
        chk("rst_acc_valid", 64'(reg_valid), 64'd1);
        chk("rst_acc_addr", 64'(reg_address), 64'h0C);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", 64'(reg_valid), 64'd0);
        chk("rst_drop_ready", 64'(host_ready), 64'd0);
        tick();
        chk("rst_hold_ready", 64'(host_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_addr", 64'(reg_address), 64'h08);
        reg_ready = 1'b1;
        tick();
        chk("post_rst_grant", 64'(host_ready), 64'h1);
        idle_inputs();
        tick();

`ifdef BLOCK_0_ACCESS_ARBITER_TIMEOUT_EN
        host_valid   = 2'b10;
        host_address = {8'h10, 8'h00};
        tick();
        for (int i = 0; i < 7; i++)
            tick();
        chk("tmo_valid_c8", 64'(reg_valid), 64'd1);
        chk("tmo_ready_c8", 64'(host_ready), 64'd0);
        tick();
        chk("tmo_ready_c9", 64'(host_ready), 64'h2);
        chk("tmo_status", 64'(host_status), 64'd2);
        chk("tmo_regvalid", 64'(reg_valid), 64'd0);
        idle_inputs();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
